// File: rtl/id_ex_pipe_if.sv
// ID/EX bus: decoded operands and controls from ID, registered copies toward EX.
interface id_ex_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RFIDX = 5
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rd1, id_rd2, id_imm;
  logic [RFIDX-1:0] id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2;
  logic [3:0]       id_aluctrl;
  logic [2:0]       id_aluctrl1;
  logic [1:0]       id_alusrca;
  logic             id_alusrcb;
  logic             id_memwrite, id_lunsigned, id_memtoreg, id_regwrite, id_j, id_btype;
  logic [1:0]       id_lwhb, id_swhb;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [RFIDX-1:0] ex_rs1, ex_rs2, ex_rd;
  logic             ex_use_rs1, ex_use_rs2;
  logic [3:0]       ex_aluctrl;
  logic [2:0]       ex_aluctrl1;
  logic [1:0]       ex_alusrca;
  logic             ex_alusrcb;
  logic             ex_memwrite, ex_lunsigned, ex_memtoreg, ex_regwrite, ex_j, ex_btype;
  logic [1:0]       ex_lwhb, ex_swhb;

  modport master (
    output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_aluctrl, id_aluctrl1, id_alusrca, id_alusrcb,
           id_memwrite, id_lunsigned, id_memtoreg, id_regwrite, id_j, id_btype,
           id_lwhb, id_swhb,
    input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_use_rs1, ex_use_rs2, ex_aluctrl, ex_aluctrl1, ex_alusrca, ex_alusrcb,
           ex_memwrite, ex_lunsigned, ex_memtoreg, ex_regwrite, ex_j, ex_btype,
           ex_lwhb, ex_swhb
  );

  modport slave (
    input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
           id_use_rs1, id_use_rs2, id_aluctrl, id_aluctrl1, id_alusrca, id_alusrcb,
           id_memwrite, id_lunsigned, id_memtoreg, id_regwrite, id_j, id_btype,
           id_lwhb, id_swhb,
    output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_use_rs1, ex_use_rs2, ex_aluctrl, ex_aluctrl1, ex_alusrca, ex_alusrcb,
           ex_memwrite, ex_lunsigned, ex_memtoreg, ex_regwrite, ex_j, ex_btype,
           ex_lwhb, ex_swhb
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall bubbles,
// downstream hold and a saturating bubble counter.
module id_ex_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RFIDX = 5,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [CNTW-1:0] bubble_cnt,
  id_ex_pipe_if.slave     bus
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc, rd1, rd2, imm;
    logic [RFIDX-1:0] rs1, rs2, rd;
    logic             use_rs1, use_rs2;
    logic [3:0]       aluctrl;
    logic [2:0]       aluctrl1;
    logic [1:0]       alusrca;
    logic             alusrcb;
    logic             memwrite, lunsigned, memtoreg, regwrite, j, btype;
    logic [1:0]       lwhb, swhb;
  } stage_t;

  stage_t          id_b;
  stage_t          ex_q;
  logic [CNTW-1:0] cnt_q;
  logic            bubble;

  // Gather the ID-side bundle
  always_comb begin
    id_b           = '0;
    id_b.valid     = bus.id_valid;
    id_b.pc        = bus.id_pc;
    id_b.rd1       = bus.id_rd1;
    id_b.rd2       = bus.id_rd2;
    id_b.imm       = bus.id_imm;
    id_b.rs1       = bus.id_rs1;
    id_b.rs2       = bus.id_rs2;
    id_b.rd        = bus.id_rd;
    id_b.use_rs1   = bus.id_use_rs1;
    id_b.use_rs2   = bus.id_use_rs2;
    id_b.aluctrl   = bus.id_aluctrl;
    id_b.aluctrl1  = bus.id_aluctrl1;
    id_b.alusrca   = bus.id_alusrca;
    id_b.alusrcb   = bus.id_alusrcb;
    id_b.memwrite  = bus.id_memwrite;
    id_b.lunsigned = bus.id_lunsigned;
    id_b.memtoreg  = bus.id_memtoreg;
    id_b.regwrite  = bus.id_regwrite;
    id_b.j         = bus.id_j;
    id_b.btype     = bus.id_btype;
    id_b.lwhb      = bus.id_lwhb;
    id_b.swhb      = bus.id_swhb;
  end

  // Load-use hazard: a load in EX whose destination the ID instruction reads; x0 never stalls
  always_comb begin
    stall_o = bus.id_valid & ex_q.valid & ex_q.memtoreg & (ex_q.rd != '0) &
              ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd)) |
               (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));
    bubble  = flush_i | stall_o;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (!hold_i) begin
      if (bubble) begin
        ex_q <= '0;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNTW'(1);
      end else begin
        ex_q <= id_b;
      end
    end
  end

  assign bubble_cnt       = cnt_q;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rd1       = ex_q.rd1;
  assign bus.ex_rd2       = ex_q.rd2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_use_rs1   = ex_q.use_rs1;
  assign bus.ex_use_rs2   = ex_q.use_rs2;
  assign bus.ex_aluctrl   = ex_q.aluctrl;
  assign bus.ex_aluctrl1  = ex_q.aluctrl1;
  assign bus.ex_alusrca   = ex_q.alusrca;
  assign bus.ex_alusrcb   = ex_q.alusrcb;
  assign bus.ex_memwrite  = ex_q.memwrite;
  assign bus.ex_lunsigned = ex_q.lunsigned;
  assign bus.ex_memtoreg  = ex_q.memtoreg;
  assign bus.ex_regwrite  = ex_q.regwrite;
  assign bus.ex_j         = ex_q.j;
  assign bus.ex_btype     = ex_q.btype;
  assign bus.ex_lwhb      = ex_q.lwhb;
  assign bus.ex_swhb      = ex_q.swhb;

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register for the five-stage xgriscv core, sitting directly downstream of the decode-stage controller. It captures the controller's control bundle and the decoded operands into the EX stage, and detects load-use hazards against the instruction it holds. It inserts bubbles on load-use stalls and on EX-stage redirects (flush), honours a downstream hold, and keeps a saturating count of inserted bubbles for performance debug.

## Interface
- XLEN, 32, datapath width
- RFIDX, 5, register index width
- CNTW, 16, bubble counter width
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- hold_i  in  1  downstream (MEM) busy; freeze this register
- flush_i  in  1  EX redirect (taken branch/jump); kill the ID instruction
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rd1, id_rd2, id_imm  in  XLEN each  PC, rs1 data, rs2 data, expanded immediate
- id_rs1, id_rs2, id_rd  in  RFIDX each  register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2
- id_aluctrl  in  4; id_aluctrl1  in  3; id_alusrca  in  2; id_alusrcb  in  1  ALU controls from the controller
- id_memwrite, id_lunsigned, id_memtoreg, id_regwrite, id_j, id_btype  in  1 each
- id_lwhb, id_swhb  in  2 each  load/store width codes (11 = w, 10 = h, 01 = b)
- ex_*  out  same widths  registered copies of every id_* data, index and control input, plus ex_valid
- stall_o  out  1  load-use stall to PC and IF/ID (combinational)
- bubble_cnt  out  CNTW  saturating count of inserted bubbles

## Operation
- Load-use detection: stall_o = id_valid & ex_valid & ex_memtoreg & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- stall_o depends only on registered ex_* state and the current ID inputs. It is independent of hold_i and flush_i.
- Per rising edge, priority is as follows:
  1. **hold_i = 1:** all ex_* outputs and bubble_cnt keep their values. flush_i and stall_o are ignored. The flush source keeps flush_i high until a non-held edge.
  2. **flush_i = 1:** load a bubble.
  3. **stall_o = 1:** load a bubble.
  4. **Otherwise:** load all id_* fields and set ex_valid = id_valid.
- A bubble sets every ex_* output to 0: ex_valid, ex_regwrite, ex_memwrite, ex_j, ex_btype, ex_aluctrl1, data and indices. All-zero equals ALU_CTRL_ZERO with no side effects.
- bubble_cnt increments by 1 on each bubble load caused by stall_o or flush_i, including flushes of an ID slot with id_valid = 0. It saturates at 2^CNTW−1 and never wraps.
- If stall_o and flush_i are both asserted, exactly one bubble is loaded and bubble_cnt increments by 1.
- After a stall bubble, the load in EX moves on, so stall_o drops. The held ID instruction then loads on the next edge. The load-use penalty is therefore exactly 1 cycle.
- ex_rd = 0 never causes a stall, even when a load targets x0.

## Timing
- Latency: id_* values present before edge N appear on ex_* right after edge N.
- stall_o is valid in the same cycle as the ID inputs, with no register.
- The upstream stages must hold PC and IF/ID in any cycle where stall_o = 1 or hold_i = 1.
- Reset (reset = 0, asynchronous): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0, so stall_o = 0.
  - All outputs stay at these values while reset is low.
  - The first capture happens on the first rising edge after reset deasserts.
- Reset asserted mid-stall or mid-hold discards the EX instruction immediately.

## Test plan
- **Pass-through:** addi x5,x1,3 in ID (id_valid = 1, id_rd = 5, id_imm = 3, id_regwrite = 1, id_aluctrl = ALU_CTRL_ADD), no hold/flush → after one edge ex_rd = 5, ex_imm = 3, ex_regwrite = 1, ex_valid = 1; bubble_cnt = 0.
- **Load-use:** lw x6,0(x2) loads into EX, then add x7,x6,x1 sits in ID (id_use_rs1 = 1) →
  - stall_o = 1 that cycle.
  - Next edge: ex_valid = 0, ex_regwrite = 0, bubble_cnt = 1.
  - Following edge: ex_rd = 7, ex_valid = 1, stall_o = 0.
- **x0 and unused operand:** lw x0 in EX with id_rs1 = 0 → stall_o = 0. lw x6 in EX with id_rs2 = 6 but id_use_rs2 = 0 → stall_o = 0.
- **Flush:** flush_i = 1 with a valid sw in ID (id_memwrite = 1) → next edge ex_memwrite = 0, ex_valid = 0, bubble_cnt += 1. With flush_i and stall_o both high, bubble_cnt increments by exactly 1.
- **Hold priority:** hold_i = 1 for 3 cycles with flush_i = 1 and changing id_* → ex_* and bubble_cnt are unchanged for all 3 edges. On the first non-held edge the bubble is loaded.
- **Saturation and reset:** with CNTW = 4, force 20 flushes → bubble_cnt = 15. Pull reset low between edges → all ex_* outputs and bubble_cnt go to 0 without a clock edge.
